// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the fetch stage: FSM encodings, instruction field
// positions, the NOP word and the default boot address.
package instr_fetch_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } fetch_state_e;

  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;
  localparam int FUNCT_MSB  = 5;
  localparam int FUNCT_LSB  = 0;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/instr_fetch_npc_logic.sv
// Purely combinational next-PC selection: sequential step, branch, jump and
// jump-register targets, with jr > jump > branch > sequential priority.
module npc_logic #(
  parameter int unsigned PC_STEP = 4
) (
  input  logic [31:0] pc,
  input  logic        jr,
  input  logic [31:0] jr_target,
  input  logic        jump,
  input  logic [25:0] jump_index,
  input  logic        branch_taken,
  input  logic [15:0] branch_imm,
  output logic [31:0] pc_plus4,
  output logic [31:0] next_pc
);

  logic [31:0] branch_off;
  logic [31:0] branch_target;
  logic [31:0] jump_target;
  logic [31:0] jr_aligned;

  assign pc_plus4      = pc + 32'(PC_STEP);
  assign branch_off    = {{14{branch_imm[15]}}, branch_imm, 2'b00};
  assign branch_target = pc_plus4 + branch_off;
  assign jump_target   = {pc_plus4[31:28], jump_index, 2'b00};
  // Misaligned register targets are silently word-aligned.
  assign jr_aligned    = {jr_target[31:2], 2'b00};

  always_comb begin
    next_pc = pc_plus4;
    if (jr)                next_pc = jr_aligned;
    else if (jump)         next_pc = jump_target;
    else if (branch_taken) next_pc = branch_target;
  end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: holds the PC, requests instruction memory (with wait states),
// registers the returned word for decode and steps the PC on redirects.
//
// state | meaning
// BOOT  | no request; one idle cycle after reset release
// REQ   | imem_req high at pc, waiting for imem_ack
// HOLD  | instr presented to decode; leaves when stall is low
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [15:0] branch_imm,
  input  logic        jump,
  input  logic [25:0] jump_index,
  input  logic        jr,
  input  logic [31:0] jr_target,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic [5:0]  funct,
  output logic        instr_valid,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus4
);

  fetch_state_e state, state_nxt;
  logic [31:0]  pc;
  logic [31:0]  next_pc;
  logic         load_instr;
  logic         advance;

  npc_logic #(.PC_STEP(PC_STEP)) u_npc (
    .pc           (pc),
    .jr           (jr),
    .jr_target    (jr_target),
    .jump         (jump),
    .jump_index   (jump_index),
    .branch_taken (branch_taken),
    .branch_imm   (branch_imm),
    .pc_plus4     (pc_plus4),
    .next_pc      (next_pc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= BOOT;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      BOOT:    state_nxt = REQ;
      REQ:     if (imem_ack) state_nxt = HOLD;
      HOLD:    if (!stall)   state_nxt = REQ;
      default: state_nxt = BOOT;
    endcase
  end

  always_comb begin
    imem_req   = (state == REQ);
    load_instr = (state == REQ) && imem_ack;
    advance    = (state == HOLD) && !stall;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc          <= RESET_PC;
      instr       <= NOP_INSTR;
      instr_valid <= 1'b0;
    end else if (load_instr) begin
      instr       <= imem_rdata;
      instr_valid <= 1'b1;
    end else if (advance) begin
      pc          <= next_pc;
      instr_valid <= 1'b0;
    end
  end

  assign imem_addr = pc;
  assign pc_out    = pc;
  assign opcode    = instr[OPCODE_MSB:OPCODE_LSB];
  assign funct     = instr[FUNCT_MSB:FUNCT_LSB];

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed fetch sequence with a memory responder;
// expected words are queued at request time and checked when instr_valid rises.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        branch_taken;
  logic [15:0] branch_imm;
  logic        jump;
  logic [25:0] jump_index;
  logic        jr;
  logic [31:0] jr_target;
  logic [31:0] instr;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic        instr_valid;
  logic [31:0] pc_out;
  logic [31:0] pc_plus4;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   total = 0;
  int   passed = 0;
  logic prev_valid = 1'b0;

  instr_fetch dut (
    .clk          (clk),
    .rst          (rst),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_imm   (branch_imm),
    .jump         (jump),
    .jump_index   (jump_index),
    .jr           (jr),
    .jr_target    (jr_target),
    .instr        (instr),
    .opcode       (opcode),
    .funct        (funct),
    .instr_valid  (instr_valid),
    .pc_out       (pc_out),
    .pc_plus4     (pc_plus4)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Monitor: each newly presented instruction must match the oldest issued fetch.
  always @(negedge clk) begin
    if (instr_valid && !prev_valid) begin
      if (exp_q.size() == 0) begin
        total++;
        $display("FAIL unexpected_instr: got %h at pc %h with no pending fetch", instr, pc_out);
      end else begin
        e = exp_q.pop_front();
        chk("instr",    instr,    e.data);
        chk("pc_out",   pc_out,   e.addr);
        chk("pc_plus4", pc_plus4, e.addr + 32'd4);
        chk("opcode",   32'(opcode), 32'(e.data[31:26]));
        chk("funct",    32'(funct),  32'(e.data[5:0]));
      end
    end
    prev_valid = instr_valid;
  end

  task automatic clear_redirects();
    branch_taken = 1'b0;
    branch_imm   = 16'h0;
    jump         = 1'b0;
    jump_index   = 26'h0;
    jr           = 1'b0;
    jr_target    = 32'h0;
  endtask

  // Waits for a request, checks its address, answers after 'waits' cycles.
  task automatic do_fetch(input int waits, input logic [31:0] data, input logic [31:0] addr);
    int n;
    n = 0;
    @(negedge clk);
    while (!imem_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!imem_req) begin
      total++;
      $display("FAIL req_timeout: no imem_req seen, required addr %h", addr);
      return;
    end
    clear_redirects();
    chk("imem_addr", imem_addr, addr);
    exp_q.push_back('{addr, data});
    for (int i = 0; i < waits; i++) begin
      imem_rdata = 32'hDEAD_BEEF;
      @(negedge clk);
      chk("req_held",       32'(imem_req),    32'd1);
      chk("addr_stable",    imem_addr,        addr);
      chk("no_early_valid", 32'(instr_valid), 32'd0);
    end
    imem_ack   = 1'b1;
    imem_rdata = data;
    @(negedge clk);
    imem_ack   = 1'b0;
    imem_rdata = 32'hDEAD_BEEF;
  endtask

  initial begin
    rst        = 1'b1;
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
    stall      = 1'b0;
    clear_redirects();

    repeat (2) @(negedge clk);
    chk("rst_req",      32'(imem_req),    32'd0);
    chk("rst_addr",     imem_addr,        32'h0);
    chk("rst_valid",    32'(instr_valid), 32'd0);
    chk("rst_instr",    instr,            32'h0);
    chk("rst_pc_plus4", pc_plus4,         32'h4);
    chk("rst_opcode",   32'(opcode),      32'd0);
    chk("rst_funct",    32'(funct),       32'd0);

    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("boot_req", 32'(imem_req), 32'd0);

    do_fetch(0, 32'h2008_0005, 32'h0000_0000);
    chk("first_opcode",   32'(opcode), 32'h08);
    chk("first_pc_plus4", pc_plus4,    32'h4);

    do_fetch(3, 32'h0000_0020, 32'h0000_0004);
    do_fetch(0, 32'h8C01_0000, 32'h0000_0008);
    do_fetch(2, 32'hAC01_0004, 32'h0000_000C);

    do_fetch(0, 32'h1000_FFFC, 32'h0000_0010);
    branch_taken = 1'b1;
    branch_imm   = 16'hFFFC;

    do_fetch(0, 32'h0800_0004, 32'h0000_0004);
    jump       = 1'b1;
    jump_index = 26'h4;

    do_fetch(1, 32'h1000_FFFC, 32'h0000_0010);
    branch_taken = 1'b1;
    branch_imm   = 16'hFFFC;
    jump         = 1'b1;
    jump_index   = 26'h40;

    do_fetch(0, 32'h0060_0008, 32'h0000_0100);
    jr           = 1'b1;
    jr_target    = 32'h0000_1003;
    jump         = 1'b1;
    jump_index   = 26'h3FF_FFFF;
    branch_taken = 1'b1;
    branch_imm   = 16'h0100;

    do_fetch(1, 32'h0123_4567, 32'h0000_1000);
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      branch_taken = ~branch_taken;
      branch_imm   = 16'h0040;
      jr           = (i == 2);
      jr_target    = 32'h0000_3000;
      imem_ack     = (i == 3);
      imem_rdata   = 32'hBAD0_BAD0;
      @(negedge clk);
      chk("stall_instr", instr,            32'h0123_4567);
      chk("stall_pc",    pc_out,           32'h0000_1000);
      chk("stall_valid", 32'(instr_valid), 32'd1);
      chk("stall_req",   32'(imem_req),    32'd0);
    end
    imem_ack = 1'b0;
    clear_redirects();
    stall = 1'b0;

    do_fetch(0, 32'h03E0_0008, 32'h0000_1004);
    jr        = 1'b1;
    jr_target = 32'hFFFF_FFFE;

    do_fetch(2, 32'h0000_0000, 32'hFFFF_FFFC);

    do_fetch(0, 32'h1000_FFF0, 32'h0000_0000);
    branch_taken = 1'b1;
    branch_imm   = 16'hFFF0;

    do_fetch(0, 32'h0000_0000, 32'hFFFF_FFC4);
    jr        = 1'b1;
    jr_target = 32'h0000_0020;

    // Reset while a request at 0x20 is still waiting for its ack.
    begin
      int n;
      n = 0;
      @(negedge clk);
      while (!imem_req && n < 20) begin
        @(negedge clk);
        n++;
      end
      clear_redirects();
      chk("midreq_addr", imem_addr, 32'h0000_0020);
      repeat (2) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("midreq_req_drop", 32'(imem_req),    32'd0);
      chk("midreq_addr_rst", imem_addr,        32'h0);
      chk("midreq_pc",       pc_out,           32'h0);
      chk("midreq_valid",    32'(instr_valid), 32'd0);
      chk("midreq_instr",    instr,            32'h0);
      @(negedge clk);
      imem_ack   = 1'b1;
      imem_rdata = 32'hBAD0_0020;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("late_ack_req",   32'(imem_req),    32'd0);
      chk("late_ack_valid", 32'(instr_valid), 32'd0);
      chk("late_ack_instr", instr,            32'h0);
      imem_ack = 1'b0;
    end

    do_fetch(0, 32'h2008_0005, 32'h0000_0000);

    @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d so far", passed, total);
    $fatal(1);
  end

endmodule
